dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sits between the CPU execute/memory stage and the word-wide data memory (dmemory32), directly upstream of it.
- Turns CPU byte, halfword and word load/store requests into word-only memory transactions.
- Performs read-modify-write for sub-word stores, and extracts and extends sub-word load data.
- Uses a valid/ready handshake toward the CPU so the pipeline can stall while a multi-cycle access runs.

Parameters:
- ADDR_W, 32, width of the CPU byte address and of mem_address.
- DATA_W, 32, word width; fixed at 32, the only supported value.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents a memory request.
- req_ready  out  1  controller accepts a request this cycle (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_rdata  out  32  load result, held until the next resp_valid.
- resp_err  out  1  misalignment flag, qualified by resp_valid.
- mem_address  out  ADDR_W  word address to dmemory32; low 2 bits always 0.
- mem_write_data  out  32  word to dmemory32.
- mem_write  out  1  write strobe to dmemory32 (its Memwrite input).
- mem_read_data  in  32  dmemory32 read data; valid the cycle after mem_address is driven.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; req_ready 1; resp_valid 0; resp_err 0; mem_write 0; mem_address 0; mem_write_data 0; resp_rdata 0; all request capture registers 0.
- Request acceptance:
  - A request is accepted when req_valid && req_ready.
  - On acceptance, addr, size, write, unsigned and wdata are latched.
  - req_ready is low from the following cycle until the cycle after resp_valid.
- State machine, states IDLE, RD, RMW_RD, WR, RESP:
  - IDLE, load accepted -> RD. mem_address = {addr[ADDR_W-1:2],2'b00}, mem_write 0.
  - IDLE, word store accepted -> WR.
  - IDLE, byte or halfword store accepted -> RMW_RD.
  - RD: sample mem_read_data, extract lane, extend, register into resp_rdata -> RESP.
  - RMW_RD: sample mem_read_data, merge the store lane into it -> WR.
  - WR: mem_write = 1 for exactly one cycle, with mem_write_data = merged word (or req_wdata for a word store) -> RESP.
  - RESP: resp_valid = 1 for one cycle -> IDLE.
- Latency, request acceptance to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Lane select:
  - byte uses addr[1:0]; lane 0 = bits 7:0 (little-endian).
  - halfword uses addr[1]; 0 selects bits 15:0, 1 selects bits 31:16.
- Extension:
  - Signed extension replicates the lane's MSB.
  - Unsigned fills with zeros.
  - Word loads pass through unchanged.
- Merge: only the addressed lane is replaced; all other bits come from the mem_read_data sampled in RMW_RD.
- For stores, resp_rdata is left unchanged.
- mem_write is never asserted outside WR.
- mem_address holds its last value while in IDLE.
- req_valid is ignored outside IDLE. A new request may be accepted in the IDLE cycle right after RESP.
- Reset mid-operation:
  - Reset aborts the operation immediately and no further mem_write occurs.
  - If reset is asserted in WR, mem_write drops asynchronously.
- Address wrap: no increment is performed, so wrap-around does not apply; the top address bits pass through unchanged.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned requests are a halfword with addr[0]=1 or a word with addr[1:0]!=0.
  - A misaligned request goes IDLE -> RESP directly, with resp_err=1 and no memory read or write. Load data is 0.
  - Latency for a misaligned request is 1 cycle.
- Not defined:
  - resp_err is tied to 0.
  - Misaligned low address bits are masked: a halfword uses addr[1], a word ignores addr[1:0].

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - the state enum
  - the constant WORD_ALIGN_MASK
- One sub-module: dmem_lane_unit, purely combinational. It performs lane extract and extend for loads and lane merge for stores, and is instantiated once.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> exactly one mem_write pulse, at cycle 1 after acceptance; load resp_rdata = 0xDEADBEEF, with resp_valid 2 cycles after acceptance.
- Memory word at 0x20 = 0x11223344; byte store 0xAA at 0x22 -> one read then one write of 0x11AA3344; resp_valid at cycle 3.
- Memory word at 0x20 = 0x80FF7F01; lb at 0x21 -> 0x0000007F; lb at 0x23 -> 0xFFFFFF80; lbu at 0x23 -> 0x00000080; lhu at 0x22 -> 0x000080FF.
- req_valid held high back-to-back -> req_ready low during RD/RMW_RD/WR/RESP; no second acceptance until IDLE; no request dropped.
- reset_n pulsed low while in WR -> mem_write drops immediately; all outputs return to reset values; the next store completes normally.
- With DMEM_ALIGN_CHECK_EN, halfword store at 0x31 -> resp_err=1 one cycle after acceptance, mem_write never asserted. Without the macro, the same store writes the lane at 0x30.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - request size encodings (byte / halfword / word)
//   - controller state enum
//   - WORD_ALIGN_MASK: low byte-address bits that must be zero for a word
//   - normalize_size(): folds the illegal size code 2'b11 onto word
package dmem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte-offset bits inside a 32-bit word; memory only ever sees them as zero.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  // Anything that is not an explicit byte or halfword is handled as a word.
  function automatic logic [1:0] normalize_size(input logic [1:0] size);
    return ((size == SZ_BYTE) || (size == SZ_HALF)) ? size : SZ_WORD;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// dmem_lane_unit
// Purely combinational lane logic for the data-memory access controller.
// Ports:
//   size        in  2   normalized access size (byte / half / word)
//   addr_lo     in  2   low byte-address bits of the captured request
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   rd_word     in  32  word read from data memory
//   wr_data     in  32  right-aligned store data
//   load_data   out 32  extracted and extended load result
//   merged_word out 32  rd_word with the addressed lane replaced by wr_data
module dmem_lane_unit
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lanes: byte lane n sits at bits 8n+7:8n, and a halfword
  // only looks at addr_lo[1], so an odd halfword address is masked down.
  assign byte_shift = {addr_lo, 3'b000};
  assign half_shift = {addr_lo[1], 4'b0000};
  assign byte_lane  = rd_word[byte_shift +: 8];
  assign half_lane  = rd_word[half_shift +: 16];

  // Extraction/extension for loads and lane merge for stores share the
  // same lane decode; word accesses pass straight through.
  always_comb begin
    load_data   = rd_word;
    merged_word = wr_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
        merged_word = rd_word;
        merged_word[byte_shift +: 8] = wr_data[7:0];
      end
      SZ_HALF: begin
        load_data   = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
        merged_word = rd_word;
        merged_word[half_shift +: 16] = wr_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Bridges CPU byte/halfword/word loads and stores onto the word-only data
// memory (dmemory32). Sub-word stores use read-modify-write; sub-word loads
// are extracted and sign/zero-extended. A valid/ready handshake lets the
// pipeline stall while an access is in flight.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word requests skip memory and return
//               resp_err = 1 after one cycle (load data 0)
//   undefined : resp_err is 0 and misaligned low address bits are masked
//
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready             CPU request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                          response
//   mem_address, mem_write_data, mem_write, mem_read_data     dmemory32 side
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t state_q;
  state_t state_d;

  logic [1:0]        size_n;
  logic              accept;
  logic              misaligned;

  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  assign size_n = normalize_size(req_size);
  assign accept = req_valid && (state_q == IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((size_n == SZ_HALF) && req_addr[0]) ||
                      ((size_n == SZ_WORD) && ((req_addr[1:0] & WORD_ALIGN_MASK) != 2'b00));
  assign resp_err   = (state_q == RESP) && err_q;

  // Error flag belongs to the request in flight and is only shown in RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // State register; reset drops straight back to IDLE, which also kills an
  // in-progress mem_write since the strobe is decoded from the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the state-decoded handshake / strobe outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned) begin
            state_d = RESP;
          end else if (!req_write) begin
            state_d = RD;
          end else if (size_n == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:      state_d = RESP;
      RMW_RD:  state_d = WR;
      WR: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and memory-side datapath. mem_address is only loaded on
  // a real access, so it holds its last value while idle; the merged word
  // for a sub-word store is formed from the read that RMW_RD sees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_lo_q      <= 2'b00;
      size_q         <= SZ_BYTE;
      unsigned_q     <= 1'b0;
      wdata_q        <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_rdata     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_lo_q  <= req_addr[1:0];
            size_q     <= size_n;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            if (misaligned) begin
              if (!req_write) begin
                resp_rdata <= '0;
              end
            end else begin
              mem_address <= {req_addr[ADDR_W-1:2], req_addr[1:0] & ~WORD_ALIGN_MASK};
              if (req_write && (size_n == SZ_WORD)) begin
                mem_write_data <= req_wdata;
              end
            end
          end
        end
        RD:      resp_rdata     <= load_data;
        RMW_RD:  mem_write_data <= merged_word;
        default: ;
      endcase
    end
  end

  dmem_lane_unit u_lane (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (unsigned_q),
    .rd_word     (mem_read_data),
    .wr_data     (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

endmodule
